aq_vlsu_ld_merge_queue: RTL and testbench
=========================================

AQ_VLSU_LD_MERGE_QUEUE -- requirements
Module: aq_vlsu_ld_merge_queue

Interface
REQ-001 Parameter DATAW, default 64, data path width in bits; legal values are 64 and 128.
REQ-002 Parameter BYTEW, default DATAW/8, byte lanes per beat.
REQ-003 Parameter DEPTH, default 2, output queue entries; power of two, 2..8.
REQ-004 Ports: forever_cpuclk  in  1  clock; one clock, all state on its rising edge.
REQ-005 Ports: cpurst_b  in  1  reset; asynchronous, active-low.
REQ-006 Ports: rtu_yy_xx_flush  in  1  synchronous flush.
REQ-007 Ports: cfg_row_bytes  in  clog2(BYTEW)+1  bytes per written-back row, 1..BYTEW, held stable while ab_vld=1 or the queue is non-empty.
REQ-008 Ports: lsu_data_vld  in  1, lsu_data  in  DATAW, lsu_bytes_vld  in  BYTEW, lsu_last  in  1, lsu_expt_vld  in  1, lsu_data_rdy  out  1.
REQ-009 Ports: wb_vld  out  1, wb_rdy  in  1, wb_data  out  DATAW, wb_bytes_vld  out  BYTEW, wb_last  out  1, wb_expt  out  1.
REQ-010 Ports: ab_vld  out  1 (accumulator non-empty), q_cnt  out  clog2(DEPTH)+1 (occupied entries).

Function
REQ-011 A beat is accepted when lsu_data_vld && lsu_data_rdy && !rtu_yy_xx_flush.
REQ-012 lsu_bytes_vld shall be contiguous from lane 0 with popcount n in the range 0..cfg_row_bytes; any other pattern is illegal input and its behaviour is unspecified.
REQ-013 The accumulator holds a fill count f in the range 0..cfg_row_bytes-1; an accepted beat's lanes are appended at byte offset f.
REQ-014 If f+n >= cfg_row_bytes, one entry shall be pushed containing the low cfg_row_bytes bytes, with the mask equal to the low cfg_row_bytes lanes set; the remaining f+n-cfg_row_bytes bytes shall shift down to lane 0 and become the new fill.
REQ-015 If f+n < cfg_row_bytes, no entry is pushed and the new fill is f+n.
REQ-016 Accepted beat with lsu_last=1: after REQ-014/015, any non-zero residual fill shall also be pushed as a partial entry, with the mask equal to the low residual lanes and wb_last=1; the final entry of the beat carries wb_last=1, and the fill becomes 0.
REQ-017 Accepted beat with lsu_expt_vld=1: the beat's data bytes are discarded; the current fill (possibly zero bytes) shall be pushed with wb_expt=1 and wb_last=1; the fill becomes 0.
REQ-018 lsu_data_rdy = (DEPTH - q_cnt) >= 2, registered-state only; there is no combinational path from wb_rdy.
REQ-019 Queue: FIFO; head entry drives wb_data, wb_bytes_vld, wb_last and wb_expt; wb_vld = q_cnt != 0; pop on wb_vld && wb_rdy.
REQ-020 Push and pop in the same cycle are legal, including two pushes and one pop; q_cnt updates by pushes minus pops.
REQ-021 Output latency: an entry pushed at edge N is visible on wb_* in cycle N+1 when the queue was empty.
REQ-022 Wrap-around: read and write pointers are clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-023 rtu_yy_xx_flush shall, at the next edge, clear the fill, all pointers and q_cnt, and shall take priority over a simultaneous accept and pop.
REQ-024 Byte lanes with their mask bit clear in wb_data are don't-care.

Reset
REQ-025 On cpurst_b low: f=0, q_cnt=0, pointers=0, wb_vld=0, ab_vld=0, lsu_data_rdy=1, wb_last=0, wb_expt=0.
REQ-026 Queue data storage and the accumulator data bytes are not reset.
REQ-027 Reset asserted mid-operation discards all buffered data without producing any output.

Structure
REQ-028 The byte-rotate/shift network shall be sub-module aq_vlsu_byte_shift, parametrised by BYTEW, taking a shift amount and a direction.
REQ-029 LSU_DATAW/LSU_BYTEW defaults and the clog2 helper belong in the shared vlsu package/header; no other shared typedefs are required.
REQ-030 Use gated clocks for the data storage, enabled on push only.

Verification
REQ-031 row=8, DATAW=64: beats n=3,3,2 -> one entry after the third beat with mask 0xFF, bytes in arrival order, f=0.
REQ-032 row=6: beats n=4 then n=4 -> entry with mask 0x3F, new f=2 holding the last two bytes of beat 2; next beat n=4 with lsu_last -> entry with mask 0x3F, wb_last=1.
REQ-033 row=8: f=5, beat n=3 with lsu_last -> exactly one entry with mask 0xFF and wb_last=1; no empty partial entry.
REQ-034 DEPTH=2, wb_rdy=0: one entry queued -> lsu_data_rdy=0; raise wb_rdy -> rdy=1 in the cycle after the pop.
REQ-035 f=3, lsu_expt_vld beat -> entry with mask 0x07, wb_expt=1, wb_last=1; beat data absent from the output.
REQ-036 Flush asserted with q_cnt=2 and f=4 -> next cycle q_cnt=0, ab_vld=0, wb_vld=0.

Source files
------------

// File: rtl/aq_vlsu_ld_merge_queue_pkg.sv
// Shared vlsu constants and helpers for the load merge queue.
package aq_vlsu_ld_merge_queue_pkg;

    localparam int LSU_DATAW = 64;
    localparam int LSU_BYTEW = LSU_DATAW / 8;

    typedef enum logic {
        SHIFT_LEFT  = 1'b0,
        SHIFT_RIGHT = 1'b1
    } shift_dir_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/aq_vlsu_ld_merge_queue_if.sv
// LSU beat input and write-back output buses of the load merge queue.
interface aq_vlsu_ld_merge_queue_if
    import aq_vlsu_ld_merge_queue_pkg::*;
#(
    parameter int DATAW = LSU_DATAW,
    parameter int BYTEW = DATAW / 8
);
    logic             lsu_data_vld;
    logic [DATAW-1:0] lsu_data;
    logic [BYTEW-1:0] lsu_bytes_vld;
    logic             lsu_last;
    logic             lsu_expt_vld;
    logic             lsu_data_rdy;
    logic             wb_vld;
    logic             wb_rdy;
    logic [DATAW-1:0] wb_data;
    logic [BYTEW-1:0] wb_bytes_vld;
    logic             wb_last;
    logic             wb_expt;

    modport slave (
        input  lsu_data_vld, lsu_data, lsu_bytes_vld, lsu_last, lsu_expt_vld, wb_rdy,
        output lsu_data_rdy, wb_vld, wb_data, wb_bytes_vld, wb_last, wb_expt
    );

    modport master (
        output lsu_data_vld, lsu_data, lsu_bytes_vld, lsu_last, lsu_expt_vld, wb_rdy,
        input  lsu_data_rdy, wb_vld, wb_data, wb_bytes_vld, wb_last, wb_expt
    );
endinterface

// File: rtl/aq_vlsu_byte_shift.sv
// Byte-granular shifter with zero fill; input and output lane counts may differ.
module aq_vlsu_byte_shift
    import aq_vlsu_ld_merge_queue_pkg::*;
#(
    parameter int BYTEW     = LSU_BYTEW,
    parameter int OUT_BYTEW = BYTEW,
    parameter int AMTW      = clog2(BYTEW) + 1
)(
    input  logic [BYTEW*8-1:0]     data_in,
    input  logic [AMTW-1:0]        shift_amt,
    input  shift_dir_e             shift_dir,
    output logic [OUT_BYTEW*8-1:0] data_out
);
    // each output lane selects its source lane, or zero when out of range
    always_comb begin
        int src;
        src      = 0;
        data_out = '0;
        for (int j = 0; j < OUT_BYTEW; j++) begin
            if (shift_dir == SHIFT_LEFT) begin
                src = j - int'(shift_amt);
            end else begin
                src = j + int'(shift_amt);
            end
            if (src >= 0 && src < BYTEW) begin
                data_out[j*8 +: 8] = data_in[src*8 +: 8];
            end else begin
                data_out[j*8 +: 8] = 8'h00;
            end
        end
    end
endmodule

// File: rtl/aq_vlsu_ld_merge_queue.sv
// Merges LSU load beats into fixed-size rows and queues them for write-back.
module aq_vlsu_ld_merge_queue
    import aq_vlsu_ld_merge_queue_pkg::*;
#(
    parameter  int DATAW = LSU_DATAW,
    parameter  int BYTEW = DATAW / 8,
    parameter  int DEPTH = 2,
    localparam int FW    = clog2(BYTEW) + 1,
    localparam int PW    = clog2(DEPTH),
    localparam int CW    = clog2(DEPTH) + 1
)(
    input  logic                     forever_cpuclk,
    input  logic                     cpurst_b,
    input  logic                     rtu_yy_xx_flush,
    input  logic [FW-1:0]            cfg_row_bytes,
    aq_vlsu_ld_merge_queue_if.slave  lsu_wb,
    output logic                     ab_vld,
    output logic [CW-1:0]            q_cnt
);
    logic [FW-1:0]      fill_r;
    logic [DATAW-1:0]   acc_data_r;
    logic [PW-1:0]      wptr_r, rptr_r;
    logic [CW-1:0]      q_cnt_r;
    logic [DATAW-1:0]   q_data_r [DEPTH];
    logic [BYTEW-1:0]   q_mask_r [DEPTH];
    logic               q_last_r [DEPTH];
    logic               q_expt_r [DEPTH];

    logic [FW-1:0]      beat_n_s, fill_nxt_s;
    logic [FW:0]        sum_s, rem_s;
    logic [DATAW-1:0]   beat_bytes_s, acc_bytes_s, res_sh_s;
    logic [2*DATAW-1:0] beat_sh_s, merged_s;
    logic               rdy_s, accept_s, pop_s, full_s;
    logic               push_a_s, push_b_s, push_a_last_s, push_a_expt_s;
    logic [DATAW-1:0]   push_a_data_s;
    logic [BYTEW-1:0]   push_a_mask_s, push_b_mask_s;
    logic [CW-1:0]      push_cnt_s;

    function automatic logic [BYTEW-1:0] lane_mask(input int cnt);
        logic [BYTEW-1:0] m;
        for (int i = 0; i < BYTEW; i++) m[i] = (i < cnt);
        return m;
    endfunction

    assign rdy_s    = q_cnt_r <= CW'(DEPTH - 2);
    assign accept_s = lsu_wb.lsu_data_vld && rdy_s && !rtu_yy_xx_flush;
    assign pop_s    = lsu_wb.wb_vld && lsu_wb.wb_rdy;

    // lane count of the beat; stale lanes of beat and accumulator forced to zero
    always_comb begin
        beat_n_s     = '0;
        beat_bytes_s = '0;
        acc_bytes_s  = '0;
        for (int i = 0; i < BYTEW; i++) begin
            if (lsu_wb.lsu_bytes_vld[i]) begin
                beat_n_s                = beat_n_s + FW'(1);
                beat_bytes_s[i*8 +: 8]  = lsu_wb.lsu_data[i*8 +: 8];
            end else begin
                beat_bytes_s[i*8 +: 8]  = 8'h00;
            end
            if (FW'(i) < fill_r) begin
                acc_bytes_s[i*8 +: 8] = acc_data_r[i*8 +: 8];
            end else begin
                acc_bytes_s[i*8 +: 8] = 8'h00;
            end
        end
    end

    aq_vlsu_byte_shift #(.BYTEW(BYTEW), .OUT_BYTEW(2*BYTEW), .AMTW(FW)) u_append_shift (
        .data_in   (beat_bytes_s),
        .shift_amt (fill_r),
        .shift_dir (SHIFT_LEFT),
        .data_out  (beat_sh_s)
    );

    assign merged_s = beat_sh_s | {{DATAW{1'b0}}, acc_bytes_s};

    aq_vlsu_byte_shift #(.BYTEW(2*BYTEW), .OUT_BYTEW(BYTEW), .AMTW(FW)) u_residual_shift (
        .data_in   (merged_s),
        .shift_amt (cfg_row_bytes),
        .shift_dir (SHIFT_RIGHT),
        .data_out  (res_sh_s)
    );

    // decide the entries produced by an accepted beat and the next fill
    always_comb begin
        sum_s         = {1'b0, fill_r} + {1'b0, beat_n_s};
        full_s        = sum_s >= {1'b0, cfg_row_bytes};
        rem_s         = full_s ? (sum_s - {1'b0, cfg_row_bytes}) : sum_s;
        fill_nxt_s    = fill_r;
        push_a_s      = 1'b0;
        push_b_s      = 1'b0;
        push_a_last_s = 1'b0;
        push_a_expt_s = 1'b0;
        push_a_data_s = merged_s[DATAW-1:0];
        push_a_mask_s = lane_mask(int'(cfg_row_bytes));
        push_b_mask_s = lane_mask(int'(rem_s));
        if (accept_s) begin
            if (lsu_wb.lsu_expt_vld) begin
                push_a_s      = 1'b1;
                push_a_last_s = 1'b1;
                push_a_expt_s = 1'b1;
                push_a_data_s = acc_bytes_s;
                push_a_mask_s = lane_mask(int'(fill_r));
                fill_nxt_s    = '0;
            end else if (full_s) begin
                push_a_s      = 1'b1;
                push_a_last_s = lsu_wb.lsu_last && (rem_s == '0);
                push_b_s      = lsu_wb.lsu_last && (rem_s != '0);
                fill_nxt_s    = lsu_wb.lsu_last ? '0 : rem_s[FW-1:0];
            end else if (lsu_wb.lsu_last && (sum_s != '0)) begin
                push_a_s      = 1'b1;
                push_a_last_s = 1'b1;
                push_a_mask_s = lane_mask(int'(sum_s));
                fill_nxt_s    = '0;
            end else begin
                fill_nxt_s    = lsu_wb.lsu_last ? '0 : sum_s[FW-1:0];
            end
        end else begin
            fill_nxt_s = fill_r;
        end
        push_cnt_s = CW'(push_a_s) + CW'(push_b_s);
    end

    // fill, pointers and occupancy; flush outranks accept and pop
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            fill_r  <= '0;
            wptr_r  <= '0;
            rptr_r  <= '0;
            q_cnt_r <= '0;
        end else if (rtu_yy_xx_flush) begin
            fill_r  <= '0;
            wptr_r  <= '0;
            rptr_r  <= '0;
            q_cnt_r <= '0;
        end else begin
            fill_r  <= fill_nxt_s;
            wptr_r  <= wptr_r + PW'(push_cnt_s);
            rptr_r  <= rptr_r + PW'(pop_s);
            q_cnt_r <= q_cnt_r + push_cnt_s - CW'(pop_s);
        end
    end

    // data storage is enabled on push only and holds no reset value
    always_ff @(posedge forever_cpuclk) begin
        if (accept_s) begin
            acc_data_r <= full_s ? res_sh_s : merged_s[DATAW-1:0];
        end
        if (push_a_s) begin
            q_data_r[wptr_r] <= push_a_data_s;
            q_mask_r[wptr_r] <= push_a_mask_s;
            q_last_r[wptr_r] <= push_a_last_s;
            q_expt_r[wptr_r] <= push_a_expt_s;
        end
        if (push_b_s) begin
            q_data_r[wptr_r + PW'(1)] <= res_sh_s;
            q_mask_r[wptr_r + PW'(1)] <= push_b_mask_s;
            q_last_r[wptr_r + PW'(1)] <= 1'b1;
            q_expt_r[wptr_r + PW'(1)] <= 1'b0;
        end
    end

    assign lsu_wb.lsu_data_rdy = rdy_s;
    assign lsu_wb.wb_vld       = q_cnt_r != '0;
    assign lsu_wb.wb_data      = q_data_r[rptr_r];
    assign lsu_wb.wb_bytes_vld = q_mask_r[rptr_r];
    assign lsu_wb.wb_last      = lsu_wb.wb_vld && q_last_r[rptr_r];
    assign lsu_wb.wb_expt      = lsu_wb.wb_vld && q_expt_r[rptr_r];
    assign ab_vld              = fill_r != '0;
    assign q_cnt               = q_cnt_r;
endmodule

// File: tb/tb_aq_vlsu_ld_merge_queue.sv
// Directed self-checking bench for the load merge queue (DATAW=64, DEPTH=2).
module tb_aq_vlsu_ld_merge_queue;
    import aq_vlsu_ld_merge_queue_pkg::*;

    localparam int DATAW = 64;
    localparam int BYTEW = 8;
    localparam int DEPTH = 2;

    logic       forever_cpuclk  = 1'b0;
    logic       cpurst_b        = 1'b0;
    logic       rtu_yy_xx_flush = 1'b0;
    logic [3:0] cfg_row_bytes   = 4'd8;
    logic       ab_vld;
    logic [1:0] q_cnt;
    int         errors = 0;
    int         checks = 0;

    aq_vlsu_ld_merge_queue_if #(.DATAW(DATAW), .BYTEW(BYTEW)) bus ();

    aq_vlsu_ld_merge_queue #(.DATAW(DATAW), .BYTEW(BYTEW), .DEPTH(DEPTH)) dut (
        .forever_cpuclk  (forever_cpuclk),
        .cpurst_b        (cpurst_b),
        .rtu_yy_xx_flush (rtu_yy_xx_flush),
        .cfg_row_bytes   (cfg_row_bytes),
        .lsu_wb          (bus.slave),
        .ab_vld          (ab_vld),
        .q_cnt           (q_cnt)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    // lanes below n carry base+lane; the rest carry filler that must never surface
    function automatic logic [63:0] beat_data(input logic [7:0] base, input int n);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = (i < n) ? (base + 8'(i)) : 8'hEE;
        return d;
    endfunction

    task automatic send_beat(input logic [7:0] base, input int n, input logic last, input logic expt);
        @(negedge forever_cpuclk);
        bus.lsu_data_vld  = 1'b1;
        bus.lsu_data      = beat_data(base, n);
        bus.lsu_bytes_vld = 8'((32'd1 << n) - 32'd1);
        bus.lsu_last      = last;
        bus.lsu_expt_vld  = expt;
        @(posedge forever_cpuclk);
        #1;
        bus.lsu_data_vld  = 1'b0;
        bus.lsu_last      = 1'b0;
        bus.lsu_expt_vld  = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge forever_cpuclk);
        bus.wb_rdy = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        bus.wb_rdy = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.wb_vld, ab_vld, q_cnt, bus.lsu_data_rdy} !== 5'b0_0_00_1) begin
            errors++;
            $display("FAIL reset_status: got %b required %b", {bus.wb_vld, ab_vld, q_cnt, bus.lsu_data_rdy}, 5'b0_0_00_1);
        end
        checks++;
        if ({bus.wb_last, bus.wb_expt} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: got %b required 00", {bus.wb_last, bus.wb_expt});
        end
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
    endtask

    task automatic test_merge_full();
        cfg_row_bytes = 4'd8;
        send_beat(8'h10, 3, 1'b0, 1'b0);
        checks++;
        if ({ab_vld, q_cnt} !== 3'b1_00) begin
            errors++;
            $display("FAIL merge_partial: got %b required 100", {ab_vld, q_cnt});
        end
        send_beat(8'h20, 3, 1'b0, 1'b0);
        send_beat(8'h30, 2, 1'b0, 1'b0);
        checks++;
        if ({bus.wb_data, bus.wb_bytes_vld} !== {64'h3130_2221_2012_1110, 8'hFF}) begin
            errors++;
            $display("FAIL merge_entry: got %h/%h required 3130222120121110/ff", bus.wb_data, bus.wb_bytes_vld);
        end
        checks++;
        if ({bus.wb_vld, bus.wb_last, bus.wb_expt, ab_vld, q_cnt, bus.lsu_data_rdy} !== 7'b1_0_0_0_01_0) begin
            errors++;
            $display("FAIL merge_status: got %b required 1000010", {bus.wb_vld, bus.wb_last, bus.wb_expt, ab_vld, q_cnt, bus.lsu_data_rdy});
        end
        pop_one();
        checks++;
        if ({bus.wb_vld, q_cnt, bus.lsu_data_rdy} !== 4'b0_00_1) begin
            errors++;
            $display("FAIL rdy_after_pop: got %b required 0001", {bus.wb_vld, q_cnt, bus.lsu_data_rdy});
        end
    endtask

    task automatic test_row6();
        cfg_row_bytes = 4'd6;
        send_beat(8'h40, 4, 1'b0, 1'b0);
        send_beat(8'h50, 4, 1'b0, 1'b0);
        checks++;
        if ({bus.wb_data[47:0], bus.wb_bytes_vld, ab_vld, q_cnt} !== {48'h5150_4342_4140, 8'h3F, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL row6_first: got %h/%h ab=%b q=%0d required 515043424140/3f ab=1 q=1", bus.wb_data[47:0], bus.wb_bytes_vld, ab_vld, q_cnt);
        end
        pop_one();
        send_beat(8'h60, 4, 1'b1, 1'b0);
        checks++;
        if ({bus.wb_data[47:0], bus.wb_bytes_vld, bus.wb_last, ab_vld, q_cnt} !== {48'h6362_6160_5352, 8'h3F, 1'b1, 1'b0, 2'd1}) begin
            errors++;
            $display("FAIL row6_last: got %h/%h last=%b ab=%b q=%0d required 636261605352/3f last=1 ab=0 q=1", bus.wb_data[47:0], bus.wb_bytes_vld, bus.wb_last, ab_vld, q_cnt);
        end
        pop_one();
        checks++;
        if (q_cnt !== 2'd0) begin
            errors++;
            $display("FAIL row6_no_extra: got q=%0d required 0", q_cnt);
        end
    endtask

    task automatic test_last();
        cfg_row_bytes = 4'd8;
        send_beat(8'h70, 5, 1'b0, 1'b0);
        send_beat(8'h80, 3, 1'b1, 1'b0);
        checks++;
        if ({bus.wb_data, bus.wb_bytes_vld, bus.wb_last, ab_vld, q_cnt} !== {64'h8281_8074_7372_7170, 8'hFF, 1'b1, 1'b0, 2'd1}) begin
            errors++;
            $display("FAIL last_exact: got %h/%h last=%b ab=%b q=%0d required 8281807473727170/ff last=1 ab=0 q=1", bus.wb_data, bus.wb_bytes_vld, bus.wb_last, ab_vld, q_cnt);
        end
        pop_one();
        send_beat(8'h90, 5, 1'b0, 1'b0);
        send_beat(8'hA0, 6, 1'b1, 1'b0);
        checks++;
        if ({bus.wb_data, bus.wb_bytes_vld, bus.wb_last, q_cnt, bus.lsu_data_rdy} !== {64'hA2A1_A094_9392_9190, 8'hFF, 1'b0, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL two_push_head: got %h/%h last=%b q=%0d rdy=%b required a2a1a09493929190/ff last=0 q=2 rdy=0", bus.wb_data, bus.wb_bytes_vld, bus.wb_last, q_cnt, bus.lsu_data_rdy);
        end
        pop_one();
        checks++;
        if ({bus.wb_data[23:0], bus.wb_bytes_vld, bus.wb_last, q_cnt} !== {24'hA5A4A3, 8'h07, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL two_push_tail: got %h/%h last=%b q=%0d required a5a4a3/07 last=1 q=1", bus.wb_data[23:0], bus.wb_bytes_vld, bus.wb_last, q_cnt);
        end
        pop_one();
        send_beat(8'h20, 3, 1'b1, 1'b0);
        checks++;
        if ({bus.wb_data[23:0], bus.wb_bytes_vld, bus.wb_last, ab_vld} !== {24'h222120, 8'h07, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL last_partial: got %h/%h last=%b ab=%b required 222120/07 last=1 ab=0", bus.wb_data[23:0], bus.wb_bytes_vld, bus.wb_last, ab_vld);
        end
        pop_one();
    endtask

    task automatic test_expt();
        cfg_row_bytes = 4'd8;
        send_beat(8'hB0, 3, 1'b0, 1'b0);
        send_beat(8'hC0, 4, 1'b0, 1'b1);
        checks++;
        if ({bus.wb_data[23:0], bus.wb_bytes_vld, bus.wb_expt, bus.wb_last, ab_vld, q_cnt} !== {24'hB2B1B0, 8'h07, 1'b1, 1'b1, 1'b0, 2'd1}) begin
            errors++;
            $display("FAIL expt_fill3: got %h/%h expt=%b last=%b ab=%b q=%0d required b2b1b0/07 expt=1 last=1 ab=0 q=1", bus.wb_data[23:0], bus.wb_bytes_vld, bus.wb_expt, bus.wb_last, ab_vld, q_cnt);
        end
        pop_one();
        send_beat(8'hD0, 2, 1'b0, 1'b1);
        checks++;
        if ({bus.wb_bytes_vld, bus.wb_expt, bus.wb_last, q_cnt} !== {8'h00, 1'b1, 1'b1, 2'd1}) begin
            errors++;
            $display("FAIL expt_empty: got %h expt=%b last=%b q=%0d required 00 expt=1 last=1 q=1", bus.wb_bytes_vld, bus.wb_expt, bus.wb_last, q_cnt);
        end
        pop_one();
    endtask

    task automatic test_flush();
        cfg_row_bytes = 4'd8;
        send_beat(8'hE0, 4, 1'b0, 1'b0);
        send_beat(8'hF0, 8, 1'b0, 1'b0);
        checks++;
        if ({ab_vld, q_cnt, bus.lsu_data_rdy} !== 4'b1_01_0) begin
            errors++;
            $display("FAIL flush_setup: got %b required 1010", {ab_vld, q_cnt, bus.lsu_data_rdy});
        end
        @(negedge forever_cpuclk);
        rtu_yy_xx_flush = 1'b1;
        bus.wb_rdy      = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        rtu_yy_xx_flush = 1'b0;
        bus.wb_rdy      = 1'b0;
        checks++;
        if ({bus.wb_vld, ab_vld, q_cnt, bus.lsu_data_rdy} !== 5'b0_0_00_1) begin
            errors++;
            $display("FAIL flush_clear: got %b required 00001", {bus.wb_vld, ab_vld, q_cnt, bus.lsu_data_rdy});
        end
        @(negedge forever_cpuclk);
        rtu_yy_xx_flush = 1'b1;
        send_beat(8'h55, 8, 1'b0, 1'b0);
        rtu_yy_xx_flush = 1'b0;
        checks++;
        if ({bus.wb_vld, ab_vld, q_cnt} !== 4'b0_0_00) begin
            errors++;
            $display("FAIL flush_vs_accept: got %b required 0000", {bus.wb_vld, ab_vld, q_cnt});
        end
        send_beat(8'h01, 8, 1'b0, 1'b0);
        checks++;
        if ({bus.wb_data, bus.wb_bytes_vld, ab_vld, q_cnt} !== {64'h0807_0605_0403_0201, 8'hFF, 1'b0, 2'd1}) begin
            errors++;
            $display("FAIL after_flush: got %h/%h ab=%b q=%0d required 0807060504030201/ff ab=0 q=1", bus.wb_data, bus.wb_bytes_vld, ab_vld, q_cnt);
        end
        pop_one();
    endtask

    task automatic test_reset_mid();
        send_beat(8'h30, 4, 1'b0, 1'b0);
        send_beat(8'h40, 8, 1'b0, 1'b0);
        @(negedge forever_cpuclk);
        cpurst_b = 1'b0;
        #1;
        checks++;
        if ({bus.wb_vld, ab_vld, q_cnt, bus.lsu_data_rdy, bus.wb_last, bus.wb_expt} !== 7'b0_0_00_1_0_0) begin
            errors++;
            $display("FAIL reset_mid: got %b required 0000100", {bus.wb_vld, ab_vld, q_cnt, bus.lsu_data_rdy, bus.wb_last, bus.wb_expt});
        end
        @(negedge forever_cpuclk);
        cpurst_b = 1'b1;
        @(posedge forever_cpuclk);
        #1;
        checks++;
        if ({bus.wb_vld, ab_vld, q_cnt} !== 4'b0_0_00) begin
            errors++;
            $display("FAIL reset_release: got %b required 0000", {bus.wb_vld, ab_vld, q_cnt});
        end
    endtask

    initial begin
        bus.lsu_data_vld  = 1'b0;
        bus.lsu_data      = 64'h0;
        bus.lsu_bytes_vld = 8'h00;
        bus.lsu_last      = 1'b0;
        bus.lsu_expt_vld  = 1'b0;
        bus.wb_rdy        = 1'b0;
        repeat (2) @(posedge forever_cpuclk);
        test_reset();
        test_merge_full();
        test_row6();
        test_last();
        test_expt();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
